btn_event_cnt: RTL
==================

BTN_EVENT_CNT -- requirements
Module: btn_event_cnt

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a debounced level change (10 ms at 100 MHz); legal range 2 to 2^20.
REQ-002 clk_100MHz_i  input  1  system clock, 100 MHz, single clock domain for the whole block.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 btn_1_i  input  1  raw asynchronous push-button, channel 1, active-high.
REQ-005 btn_2_i  input  1  raw asynchronous push-button, channel 2, active-high.
REQ-006 clr_i  input  1  raw asynchronous clear button, active-high.
REQ-007 cnt_val_1_o  output  16  channel 1 press count, 4 packed BCD digits, [15:12] thousands to [3:0] units; feeds the display driver's cnt_val_1_i.
REQ-008 cnt_val_2_o  output  16  channel 2 press count, same format; feeds cnt_val_2_i.
REQ-009 event_1_o / event_2_o  output  1 each  one-cycle pulse per accepted press.

Function
REQ-010 Each raw input (btn_1_i, btn_2_i, clr_i) SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each synchronized input SHALL feed a debouncer: a stable level register plus a 20-bit counter.
REQ-012 Debouncer counter: cleared whenever synced input equals stable level; otherwise incremented each cycle.
REQ-013 Debouncer update: when the counter reaches DEBOUNCE_CYCLES-1 with input still differing, the stable level SHALL toggle and the counter SHALL clear on the same edge.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-015 Rising edge of a stable level SHALL produce a one-cycle pulse the following cycle; falling edges produce nothing.
REQ-016 Latency: event_x_o SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the raw input rises and holds.
REQ-017 Counter update: on the edge after event_x_o is high, cnt_val_x_o SHALL increment by 1 in BCD.
REQ-018 BCD carry: any digit at 9 SHALL become 0 and carry into the next digit; no digit SHALL ever hold A-F.
REQ-019 Wrap-around: 9999 + 1 SHALL give 0000, with no sticky or overflow flag.
REQ-020 Clear: a debounced clr rising-edge pulse SHALL zero both counters on the next edge.
REQ-021 Simultaneous clear and channel event in the same cycle: clear SHALL win and the counter SHALL read 0000.
REQ-022 Channels SHALL be fully independent; simultaneous events on both SHALL increment both.
REQ-023 Holding a button SHALL count once; the next count requires a debounced release then press.

Reset
REQ-024 Asynchronous assertion of rst_n=0 SHALL immediately force all synchronizer flops, stable levels and debounce counters to 0.
REQ-025 Reset SHALL force event_1_o=event_2_o=0 and cnt_val_1_o=cnt_val_2_o=16'h0000.
REQ-026 Reset mid-debounce SHALL discard the partial count, and no event SHALL fire from pre-reset activity.
REQ-027 A button held through reset release SHALL produce one event after DEBOUNCE_CYCLES+3 cycles.

Structure
REQ-028 Shared package SHALL hold BCD_DIGITS=4, CNT_W=16 and DEB_CNT_W=20.
REQ-029 Sub-module btn_debounce SHALL contain synchronizer, debouncer and rise-pulse logic, parameterized by DEBOUNCE_CYCLES.
REQ-030 btn_debounce SHALL be instantiated three times.
REQ-031 BCD increment SHALL be a per-digit combinational function in the package, not a separate module.
REQ-032 Target size: 150-300 lines total.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 btn_1_i high 20 cycles -> single event_1_o pulse 7 cycles after rise; cnt_val_1_o 0000->0001; cnt_val_2_o stays 0000.
REQ-034 btn_2_i 3-cycle glitches repeated 10 times -> no event_2_o, cnt_val_2_o remains 0000.
REQ-035 Preload 9999 via 9999 presses, then press once -> 0000; also 0009->0010 and 0099->0100.
REQ-036 clr_i and btn_1_i pressed on the same cycle with cnt_val_1_o=0005 -> 0000 after both pulses, not 0001.
REQ-037 Assert rst_n low during cycle 5 of a held btn_1_i -> outputs 0 immediately; after release, press counted once at +7 cycles.
REQ-038 Both buttons pressed on the same cycle 3 times -> both outputs read 0003.

Source files
------------

// File: rtl/btn_event_cnt_pkg.sv
// Shared widths and the BCD increment helper for the two-channel press counter.
package btn_event_cnt_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int CNT_W      = 16;
    localparam int DEB_CNT_W  = 20;

    // Returns {carry_out, digit_out}; a carry-in on 9 rolls the digit to 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic carry);
        logic [4:0] res;
        res = {1'b0, digit};
        if (carry) begin
            if (digit >= 4'd9) begin
                res = 5'b1_0000;
            end else begin
                res = {1'b0, digit + 4'd1};
            end
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        logic [4:0]       dig;
        logic             carry;
        res   = '0;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            dig            = bcd_digit_inc(val[4*i +: 4], carry);
            res[4*i +: 4]  = dig[3:0];
            carry          = dig[4];
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter-based debouncer and registered rising-edge pulse.
module btn_debounce
    import btn_event_cnt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    localparam logic [DEB_CNT_W-1:0] TC = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           sync;
    logic                 level;
    logic                 level_d;
    logic [DEB_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Pulse lands one cycle after the level rises.
            level_d <= level;
            rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/btn_event_cnt.sv
// Two debounced push-button channels counting presses in 4-digit BCD, with a debounced clear.
module btn_event_cnt
    import btn_event_cnt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk_100MHz_i,
    input  logic             rst_n,
    input  logic             btn_1_i,
    input  logic             btn_2_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_val_1_o,
    output logic [CNT_W-1:0] cnt_val_2_o,
    output logic             event_1_o,
    output logic             event_2_o
);

    logic clr_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_1 (
        .clk   (clk_100MHz_i),
        .rst_n (rst_n),
        .din   (btn_1_i),
        .rise  (event_1_o)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_2 (
        .clk   (clk_100MHz_i),
        .rst_n (rst_n),
        .din   (btn_2_i),
        .rise  (event_2_o)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk   (clk_100MHz_i),
        .rst_n (rst_n),
        .din   (clr_i),
        .rise  (clr_evt)
    );

    // Clear takes priority over a press arriving in the same cycle.
    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val_1_o <= '0;
            cnt_val_2_o <= '0;
        end else if (clr_evt) begin
            cnt_val_1_o <= '0;
            cnt_val_2_o <= '0;
        end else begin
            if (event_1_o) cnt_val_1_o <= bcd_inc(cnt_val_1_o);
            if (event_2_o) cnt_val_2_o <= bcd_inc(cnt_val_2_o);
        end
    end

endmodule
